// File: rtl/fade_pkg.sv
// Shared types and constants for the fade_ramp brightness sequencer.
// Optional build macro used by fade_ramp: FADE_RAMP_BREATHE_EN.
package fade_pkg;

  localparam int DEFAULT_WIDTH  = 12;
  localparam int DEFAULT_RATE_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } state_e;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/rate_prescaler.sv
// Programmable step-rate divider: counts 0..rate while enabled and pulses tick
// on the terminal count. Reusable by other LED sequencing blocks.
module rate_prescaler
  import fade_pkg::*;
#(
  parameter int RATE_W = DEFAULT_RATE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] count_q;
  logic [RATE_W-1:0] count_d;

  assign tick = en && (count_q == rate);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = tick ? '0 : count_q + RATE_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fade_ramp.sv
// Brightness sequencer feeding the pwm stage: walks brightness one LSB per
// prescaler tick toward a commanded target. Build macro: FADE_RAMP_BREATHE_EN.
module fade_ramp
  import fade_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int RATE_W     = DEFAULT_RATE_W,
  parameter int INIT_LEVEL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  target,
  input  logic [RATE_W-1:0] rate,
  input  logic              cmd_valid,
`ifdef FADE_RAMP_BREATHE_EN
  input  logic              breathe,
`endif
  output logic              cmd_ready,
  output logic [WIDTH-1:0]  brightness,
  output logic              busy,
  output logic              done
);

  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT_LEVEL);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  brightness_q, brightness_d;
  logic [WIDTH-1:0]  target_q, target_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              done_q, done_d;

  logic              cmd_take;
  logic [WIDTH-1:0]  cmd_target;
  logic [RATE_W-1:0] cmd_rate;
  logic              tick;
  logic              dir;

  // Command source: external handshake, or a self-issued triangle-fade leg.
`ifdef FADE_RAMP_BREATHE_EN
  localparam logic [WIDTH-1:0] MID_LEVEL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_LEVEL = '1;

  always_comb begin
    cmd_take   = (state_q == IDLE) && (cmd_valid || breathe);
    cmd_target = target;
    cmd_rate   = rate;
    if (!cmd_valid) begin
      cmd_target = (brightness_q >= MID_LEVEL) ? '0 : MAX_LEVEL;
    end
  end
`else
  always_comb begin
    cmd_take   = (state_q == IDLE) && cmd_valid;
    cmd_target = target;
    cmd_rate   = rate;
  end
`endif

  rate_prescaler #(
    .RATE_W(RATE_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clear(cmd_take),
    .en   (state_q == RAMP),
    .rate (rate_q),
    .tick (tick)
  );

  assign dir = (brightness_q < target_q) ? DIR_UP : DIR_DOWN;

  always_comb begin
    target_d     = target_q;
    rate_d       = rate_q;
    brightness_d = brightness_q;
    done_d       = 1'b0;
    if (cmd_take) begin
      target_d = cmd_target;
      rate_d   = cmd_rate;
      done_d   = (cmd_target == brightness_q);
    end
    // In RAMP brightness differs from target, so a step never passes it or wraps.
    if ((state_q == RAMP) && tick && (brightness_q != target_q)) begin
      brightness_d = (dir == DIR_UP) ? brightness_q + WIDTH'(1)
                                     : brightness_q - WIDTH'(1);
      done_d       = (brightness_d == target_q);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (cmd_take && (cmd_target != brightness_q)) state_d = RAMP;
      RAMP: if (tick && (brightness_d == target_q))       state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      brightness_q <= INIT_VAL;
      target_q     <= INIT_VAL;
      rate_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      brightness_q <= brightness_d;
      target_q     <= target_d;
      rate_q       <= rate_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RAMP);
  end

  assign brightness = brightness_q;
  assign done       = done_q;

endmodule

// File: tb/tb_fade_ramp.sv
// Directed self-checking bench for fade_ramp with hand-computed expectations.
// Breathe checks are built when FADE_RAMP_BREATHE_EN is defined.
module tb_fade_ramp;

  logic        clk;
  logic        reset;
  logic [11:0] target;
  logic [15:0] rate;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [11:0] brightness;
  logic        busy;
  logic        done;
`ifdef FADE_RAMP_BREATHE_EN
  logic        breathe;
`endif

  int errors = 0;
  int checks = 0;

  fade_ramp dut (
    .clk       (clk),
    .reset     (reset),
    .target    (target),
    .rate      (rate),
    .cmd_valid (cmd_valid),
`ifdef FADE_RAMP_BREATHE_EN
    .breathe   (breathe),
`endif
    .cmd_ready (cmd_ready),
    .brightness(brightness),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one command at a negedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [11:0] tgt, input logic [15:0] rt);
    target    = tgt;
    rate      = rt;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  int cycles;
  int done_count;
  int back_steps;
  int prev;

  initial begin
    reset     = 1'b1;
    target    = '0;
    rate      = '0;
    cmd_valid = 1'b0;
`ifdef FADE_RAMP_BREATHE_EN
    breathe   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checkOutput("rst_brightness", 32'(brightness), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_ready", 32'(cmd_ready), 1);
    reset = 1'b0;
    @(negedge clk);

    // Up ramp 0 -> 5 at one step per clock.
    applyStimulus(12'd5, 16'd0);
    checkOutput("up_busy_rise", 32'(busy), 1);
    checkOutput("up_ready_low", 32'(cmd_ready), 0);
    checkOutput("up_start_level", 32'(brightness), 0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      checkOutput($sformatf("up_level_%0d", k), 32'(brightness), 32'(k));
      checkOutput($sformatf("up_done_%0d", k), 32'(done), (k == 5) ? 1 : 0);
      checkOutput($sformatf("up_busy_%0d", k), 32'(busy), (k == 5) ? 0 : 1);
    end
    checkOutput("up_ready_back", 32'(cmd_ready), 1);
    @(negedge clk);
    checkOutput("up_done_single", 32'(done), 0);
    checkOutput("up_hold_level", 32'(brightness), 5);

    // Down ramp 5 -> 2, one step every 4 clocks.
    applyStimulus(12'd2, 16'd3);
    checkOutput("dn_start_level", 32'(brightness), 5);
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      checkOutput($sformatf("dn_level_%0d", n), 32'(brightness), 32'(5 - n / 4));
      checkOutput($sformatf("dn_done_%0d", n), 32'(done), (n == 12) ? 1 : 0);
      checkOutput($sformatf("dn_busy_%0d", n), 32'(busy), (n == 12) ? 0 : 1);
    end
    @(negedge clk);
    checkOutput("dn_done_single", 32'(done), 0);

    // Target equal to current level: immediate done, no ramp.
    applyStimulus(12'd2, 16'd7);
    checkOutput("eq_busy", 32'(busy), 0);
    checkOutput("eq_done", 32'(done), 1);
    checkOutput("eq_level", 32'(brightness), 2);
    @(negedge clk);
    checkOutput("eq_done_single", 32'(done), 0);
    checkOutput("eq_level_hold", 32'(brightness), 2);

    // Full-range ramp 0 -> 4095 at rate 0.
    pulseReset();
    applyStimulus(12'd4095, 16'd0);
    cycles = 0; done_count = 0; back_steps = 0; prev = 0;
    for (int i = 0; i < 5000; i++) begin
      if (done) done_count++;
      if (int'(brightness) < prev) back_steps++;
      prev = int'(brightness);
      if (!busy) break;
      cycles++;
      @(negedge clk);
    end
    checkOutput("full_cycles", 32'(cycles), 4095);
    checkOutput("full_final", 32'(brightness), 4095);
    checkOutput("full_done_count", 32'(done_count), 1);
    checkOutput("full_no_wrap", 32'(back_steps), 0);
    @(negedge clk);
    checkOutput("full_hold", 32'(brightness), 4095);

    // Command held during a ramp is taken only when cmd_ready returns.
    pulseReset();
    applyStimulus(12'd50, 16'd0);
    target    = 12'd100;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (cmd_ready) break;
      @(negedge clk);
    end
    checkOutput("hold_ready_level", 32'(brightness), 50);
    checkOutput("hold_ready_done", 32'(done), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    checkOutput("hold_accept_busy", 32'(busy), 1);
    checkOutput("hold_accept_level", 32'(brightness), 50);
    cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    checkOutput("hold_cycles", 32'(cycles), 50);
    checkOutput("hold_final", 32'(brightness), 100);

    // Asynchronous reset in the middle of a ramp.
    pulseReset();
    applyStimulus(12'd100, 16'd0);
    repeat (37) @(negedge clk);
    checkOutput("mid_level", 32'(brightness), 37);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_level", 32'(brightness), 0);
    checkOutput("async_busy", 32'(busy), 0);
    checkOutput("async_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_done", 32'(done), 0);
    checkOutput("post_rst_ready", 32'(cmd_ready), 1);
    checkOutput("post_rst_level", 32'(brightness), 0);

`ifdef FADE_RAMP_BREATHE_EN
    // Breathe: self-issued triangle 0 -> 4095 -> 0.
    rate    = 16'd0;
    breathe = 1'b1;
    cycles  = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    checkOutput("br_up_cycles", 32'(cycles), 4096);
    checkOutput("br_top", 32'(brightness), 4095);
    cycles = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      cycles++;
      if (done) break;
    end
    breathe = 1'b0;
    checkOutput("br_dn_cycles", 32'(cycles), 4096);
    checkOutput("br_bottom", 32'(brightness), 0);
    @(negedge clk);
    checkOutput("br_stop_busy", 32'(busy), 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
